// File: rtl/duck_spawner.sv
// Sequences one duck's life: random spawn delay, random lane and direction,
// horizontal flight, then a fall when shot or an escape at the screen edge.
module duck_spawner #(
   parameter int RAND_W     = 2,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int X_MAX      = 152,
   parameter int X_STEP     = 4,
   parameter int LANE0_Y    = 8,
   parameter int LANE_STEP  = 16,
   parameter int GROUND_Y   = 104,
   parameter int FALL_STEP  = 4,
   parameter int DELAY_UNIT = 8,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              game_en,
   input  logic              move_tick,
   input  logic [RAND_W-1:0] rand_in,
   input  logic              hit,
   output logic              rand_next,
   output logic              duck_active,
   output logic              duck_falling,
   output logic              duck_dir,
   output logic [X_W-1:0]    duck_x,
   output logic [Y_W-1:0]    duck_y,
   output logic              spawned,
   output logic              escaped,
   output logic              downed
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LANE,
      S_DIR,
      S_FLY,
      S_FALL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] delay_q, delay_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic             dir_q, dir_d;
   logic             active_q, active_d;
   logic             falling_q, falling_d;
   logic             rand_next_q, rand_next_d;
   logic             spawned_q, spawned_d;
   logic             escaped_q, escaped_d;
   logic             downed_q, downed_d;

   // One bit of headroom so edge and ground compares never see a wrapped value
   logic [X_W:0]     x_inc;
   logic [Y_W:0]     y_inc;

   assign x_inc = {1'b0, x_q} + (X_W+1)'(X_STEP);
   assign y_inc = {1'b0, y_q} + (Y_W+1)'(FALL_STEP);

   always_comb begin
      state_d     = state_q;
      delay_d     = delay_q;
      x_d         = x_q;
      y_d         = y_q;
      dir_d       = dir_q;
      active_d    = active_q;
      falling_d   = falling_q;
      rand_next_d = 1'b0;
      spawned_d   = 1'b0;
      escaped_d   = 1'b0;
      downed_d    = 1'b0;

      if (!game_en) begin
         state_d   = S_IDLE;
         delay_d   = '0;
         active_d  = 1'b0;
         falling_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               delay_d     = (CNT_W'(rand_in) + CNT_W'(1)) * CNT_W'(DELAY_UNIT);
               rand_next_d = 1'b1;
               state_d     = S_WAIT;
            end
            S_WAIT: begin
               if (move_tick) begin
                  if (delay_q == CNT_W'(1)) begin
                     rand_next_d = 1'b1;
                     state_d     = S_LANE;
                  end
                  delay_d = delay_q - CNT_W'(1);
               end
            end
            S_LANE: begin
               // rand_next is high during this cycle, so DIR samples a fresh value
               y_d     = Y_W'((Y_W+1)'(LANE0_Y) + (Y_W+1)'(rand_in) * (Y_W+1)'(LANE_STEP));
               state_d = S_DIR;
            end
            S_DIR: begin
               dir_d     = rand_in[0];
               x_d       = rand_in[0] ? '0 : X_W'(X_MAX);
               spawned_d = 1'b1;
               active_d  = 1'b1;
               state_d   = S_FLY;
            end
            S_FLY: begin
               if (hit) begin
                  falling_d = 1'b1;
                  state_d   = S_FALL;
               end else if (move_tick) begin
                  if (dir_q) begin
                     if (x_inc > (X_W+1)'(X_MAX)) begin
                        escaped_d = 1'b1;
                        active_d  = 1'b0;
                        state_d   = S_IDLE;
                     end else begin
                        x_d = x_inc[X_W-1:0];
                     end
                  end else begin
                     if (x_q < X_W'(X_STEP)) begin
                        escaped_d = 1'b1;
                        active_d  = 1'b0;
                        state_d   = S_IDLE;
                     end else begin
                        x_d = x_q - X_W'(X_STEP);
                     end
                  end
               end
            end
            S_FALL: begin
               if (move_tick) begin
                  if (y_inc >= (Y_W+1)'(GROUND_Y)) begin
                     y_d       = Y_W'(GROUND_Y);
                     downed_d  = 1'b1;
                     active_d  = 1'b0;
                     falling_d = 1'b0;
                     state_d   = S_IDLE;
                  end else begin
                     y_d = y_inc[Y_W-1:0];
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         delay_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         dir_q       <= 1'b0;
         active_q    <= 1'b0;
         falling_q   <= 1'b0;
         rand_next_q <= 1'b0;
         spawned_q   <= 1'b0;
         escaped_q   <= 1'b0;
         downed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         delay_q     <= delay_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_q       <= dir_d;
         active_q    <= active_d;
         falling_q   <= falling_d;
         rand_next_q <= rand_next_d;
         spawned_q   <= spawned_d;
         escaped_q   <= escaped_d;
         downed_q    <= downed_d;
      end
   end

   assign rand_next    = rand_next_q;
   assign duck_active  = active_q;
   assign duck_falling = falling_q;
   assign duck_dir     = dir_q;
   assign duck_x       = x_q;
   assign duck_y       = y_q;
   assign spawned      = spawned_q;
   assign escaped      = escaped_q;
   assign downed       = downed_q;

endmodule
